// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared widths, memory op codes and FSM types for the memory stage
package mem_access_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MEM_OP_W   = 4;

  localparam logic [REG_BUS_W-1:0] ZERO_WORD     = '0;
  localparam logic                 WRITE_DISABLE = 1'b0;

  // Plain constants rather than an enum: undefined codes 9..15 must flow through as NONE.
  localparam logic [MEM_OP_W-1:0] MEMOP_NONE = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEMOP_LB   = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEMOP_LBU  = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEMOP_LH   = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEMOP_LHU  = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEMOP_LW   = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEMOP_SB   = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEMOP_SH   = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEMOP_SW   = 4'd8;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  function automatic size_e op_size(input logic [MEM_OP_W-1:0] op);
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: return SZ_BYTE;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: return SZ_HALF;
      MEMOP_LW, MEMOP_SW:            return SZ_WORD;
      default:                       return SZ_NONE;
    endcase
  endfunction

  function automatic logic op_is_load(input logic [MEM_OP_W-1:0] op);
    return (op >= MEMOP_LB) && (op <= MEMOP_LW);
  endfunction

  function automatic logic op_is_store(input logic [MEM_OP_W-1:0] op);
    return (op >= MEMOP_SB) && (op <= MEMOP_SW);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - big-endian lane select and sign/zero extension of load data
module mem_load_align
  import mem_access_pkg::*;
(
  input  logic [REG_BUS_W-1:0] i_rdata,
  input  logic [1:0]           i_addr,
  input  logic [MEM_OP_W-1:0]  i_op,
  output logic [REG_BUS_W-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane 0 is the most significant byte.
  always_comb begin
    w_byte = 8'h00;
    case (i_addr)
      2'b00: w_byte = i_rdata[31:24];
      2'b01: w_byte = i_rdata[23:16];
      2'b10: w_byte = i_rdata[15:8];
      2'b11: w_byte = i_rdata[7:0];
      default: w_byte = 8'h00;
    endcase
    w_half = i_addr[1] ? i_rdata[15:0] : i_rdata[31:16];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_op)
      MEMOP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MEMOP_LBU: o_data = {24'h000000, w_byte};
      MEMOP_LH:  o_data = {{16{w_half[15]}}, w_half};
      MEMOP_LHU: o_data = {16'h0000, w_half};
      default:   o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory stage: pass-through, bus req/ack access with stall and timeout
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ex_waddr,
  input  logic [REG_BUS_W-1:0]  ex_wdata,
  input  logic                  ex_we,
  input  logic [MEM_OP_W-1:0]   ex_memop,
  input  logic [REG_BUS_W-1:0]  ex_addr,
  input  logic [REG_BUS_W-1:0]  ex_sdata,
  output logic [REG_ADDR_W-1:0] mem_waddr,
  output logic [REG_BUS_W-1:0]  mem_wdata,
  output logic                  mem_we,
  output logic                  stallreq,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [REG_BUS_W-1:0]  bus_addr,
  output logic [3:0]            bus_be,
  output logic [REG_BUS_W-1:0]  bus_wdata,
  input  logic [REG_BUS_W-1:0]  bus_rdata,
  input  logic                  bus_ack,
  output logic                  addr_err,
  output logic                  bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e              r_state;
  state_e              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_bus_req;
  logic                r_bus_we;
  logic [REG_BUS_W-1:0] r_bus_addr;
  logic [3:0]          r_bus_be;
  logic [REG_BUS_W-1:0] r_bus_wdata;

  size_e               w_size;
  logic                w_is_load;
  logic                w_is_mem;
  logic                w_misaligned;
  logic [3:0]          w_be;
  logic [REG_BUS_W-1:0] w_store_data;
  logic [REG_BUS_W-1:0] w_load_data;
  logic                w_launch;
  logic                w_finish;

  assign w_size       = op_size(ex_memop);
  assign w_is_load    = op_is_load(ex_memop);
  assign w_is_mem     = w_is_load || op_is_store(ex_memop);
  assign w_misaligned = ((w_size == SZ_HALF) && ex_addr[0]) ||
                        ((w_size == SZ_WORD) && (ex_addr[1:0] != 2'b00));

  always_comb begin
    w_be         = 4'b0000;
    w_store_data = ex_sdata;
    case (w_size)
      SZ_BYTE: begin
        w_be         = 4'b1000 >> ex_addr[1:0];
        w_store_data = {4{ex_sdata[7:0]}};
      end
      SZ_HALF: begin
        w_be         = ex_addr[1] ? 4'b0011 : 4'b1100;
        w_store_data = {2{ex_sdata[15:0]}};
      end
      SZ_WORD: w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  mem_load_align u_load_align (
    .i_rdata (bus_rdata),
    .i_addr  (ex_addr[1:0]),
    .i_op    (ex_memop),
    .o_data  (w_load_data)
  );

  always_comb begin
    mem_waddr = ex_waddr;
    mem_wdata = ex_wdata;
    mem_we    = ex_we;
    stallreq  = 1'b0;
    addr_err  = 1'b0;
    bus_err   = 1'b0;
    w_next    = r_state;
    w_launch  = 1'b0;
    w_finish  = 1'b0;
    if (rst) begin
      mem_waddr = '0;
      mem_wdata = ZERO_WORD;
      mem_we    = WRITE_DISABLE;
      w_next    = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_is_mem) begin
            mem_we = WRITE_DISABLE;
            if (w_misaligned) begin
              addr_err = 1'b1;
            end else begin
              stallreq = 1'b1;
              w_launch = 1'b1;
              w_next   = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          mem_we = WRITE_DISABLE;
          // An ack in the final timeout cycle still completes normally.
          if (bus_ack) begin
            w_finish = 1'b1;
            w_next   = ST_IDLE;
            if (w_is_load) begin
              mem_we    = ex_we;
              mem_wdata = w_load_data;
            end
          end else if (r_cnt == CNT_LAST) begin
            bus_err  = 1'b1;
            w_finish = 1'b1;
            w_next   = ST_IDLE;
          end else begin
            stallreq = 1'b1;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= ZERO_WORD;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= ZERO_WORD;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= op_is_store(ex_memop);
        r_bus_addr  <= {ex_addr[31:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= w_store_data;
        r_cnt       <= '0;
      end else if (r_state == ST_BUSY) begin
        if (w_finish) r_bus_req <= 1'b0;
        else          r_cnt     <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - directed vector bench for mem_access
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        ex_we;
  logic [3:0]  ex_memop;
  logic [31:0] ex_addr;
  logic [31:0] ex_sdata;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        stallreq;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        addr_err;
  logic        bus_err;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_we(ex_we), .ex_memop(ex_memop),
    .ex_addr(ex_addr), .ex_sdata(ex_sdata),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we), .stallreq(stallreq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        we;
    logic        e_we;
    logic        e_aerr;
    logic        chk_data;
  } vec_t;

  vec_t vecs[6];

  // ack_at: BUSY cycle (1 = first) in which bus_ack is driven; 0 = never.
  task automatic do_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [31:0] rdata, input int ack_at,
                           output int stall_n, output int err_at, output logic got_we,
                           output logic [31:0] got_wdata, output logic [31:0] b_addr,
                           output logic [3:0] b_be, output logic [31:0] b_wdata,
                           output logic b_we, output logic stable);
    int  k;
    logic done;
    k = 0; stall_n = 0; err_at = 0; got_we = 1'b0; got_wdata = '0;
    b_addr = '0; b_be = '0; b_wdata = '0; b_we = 1'b0; stable = 1'b1; done = 1'b0;
    @(posedge clk); #1;
    ex_memop = op; ex_addr = addr; ex_sdata = sdata; ex_waddr = 5'd9;
    ex_we = 1'b1; ex_wdata = 32'h5555_AAAA; bus_rdata = rdata; bus_ack = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (bus_req) begin
        k++;
        bus_ack = (k == ack_at);
        if (k == 1) begin
          b_addr = bus_addr; b_be = bus_be; b_wdata = bus_wdata; b_we = bus_we;
        end else if (bus_addr !== b_addr || bus_be !== b_be || bus_wdata !== b_wdata || bus_we !== b_we) begin
          stable = 1'b0;
        end
      end else begin
        bus_ack = 1'b0;
      end
      @(negedge clk);
      if (stallreq) stall_n++;
      else begin
        done = 1'b1; got_we = mem_we; got_wdata = mem_wdata;
        if (bus_err) err_at = k;
      end
    end
    if (!done) check("access_hang", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus_ack = 1'b0; ex_memop = 4'd0;
    check("req_drop_after_done", bus_req, 1'b0);
  endtask

  int          st_n, e_at;
  logic        g_we, g_st, g_bwe;
  logic [31:0] g_wd, g_ba, g_bwd;
  logic [3:0]  g_be;

  initial begin
    vecs[0] = '{"none_pass",   4'd0, 32'h0,     5'd3,  32'h0000_1234, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{"undef_pass",  4'hF, 32'h7,     5'd7,  32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{"none_we0",    4'd0, 32'h0,     5'd31, 32'hA5A5_0F0F, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{"lw_mis_003",  4'd5, 32'h003,   5'd4,  32'h1111_1111, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{"lh_mis_001",  4'd3, 32'h001,   5'd4,  32'h2222_2222, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{"sw_mis_102",  4'd8, 32'h102,   5'd4,  32'h3333_3333, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; ex_waddr = 5'd3; ex_wdata = 32'h1234; ex_we = 1'b1; ex_memop = 4'd0;
    ex_addr = '0; ex_sdata = '0; bus_rdata = '0; bus_ack = 1'b0;
    @(negedge clk);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk); #1;
    check("rst_bus_req", bus_req, 1'b0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_be", bus_be, 4'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      ex_memop = vecs[i].op; ex_addr = vecs[i].addr; ex_waddr = vecs[i].waddr;
      ex_wdata = vecs[i].wdata; ex_we = vecs[i].we;
      @(negedge clk);
      check({vecs[i].name, "_we"}, mem_we, vecs[i].e_we);
      check({vecs[i].name, "_aerr"}, addr_err, vecs[i].e_aerr);
      check({vecs[i].name, "_stall"}, stallreq, 1'b0);
      if (vecs[i].chk_data) begin
        check({vecs[i].name, "_waddr"}, mem_waddr, vecs[i].waddr);
        check({vecs[i].name, "_wdata"}, mem_wdata, vecs[i].wdata);
      end
      @(posedge clk); #1;
      check({vecs[i].name, "_noreq"}, bus_req, 1'b0);
      ex_memop = 4'd0;
    end

    do_access(4'd1, 32'h101, 32'h0, 32'h1180_2233, 1, st_n, e_at, g_we, g_wd, g_ba, g_be, g_bwd, g_bwe, g_st);
    check("lb_addr", g_ba, 32'h100);
    check("lb_be", g_be, 4'b0100);
    check("lb_wdata", g_wd, 32'hFFFF_FF80);
    check("lb_we", g_we, 1'b1);
    check("lb_stall", st_n, 1);

    do_access(4'd2, 32'h101, 32'h0, 32'h1180_2233, 1, st_n, e_at, g_we, g_wd, g_ba, g_be, g_bwd, g_bwe, g_st);
    check("lbu_wdata", g_wd, 32'h0000_0080);

    do_access(4'd7, 32'h202, 32'hABCD, 32'h0, 4, st_n, e_at, g_we, g_wd, g_ba, g_be, g_bwd, g_bwe, g_st);
    check("sh_addr", g_ba, 32'h200);
    check("sh_be", g_be, 4'b0011);
    check("sh_bwdata", g_bwd, 32'hABCD_ABCD);
    check("sh_bwe", g_bwe, 1'b1);
    check("sh_mem_we", g_we, 1'b0);
    check("sh_stall", st_n, 4);
    check("sh_stable", g_st, 1'b1);

    do_access(4'd6, 32'h003, 32'h1234_565A, 32'h0, 2, st_n, e_at, g_we, g_wd, g_ba, g_be, g_bwd, g_bwe, g_st);
    check("sb_be", g_be, 4'b0001);
    check("sb_bwdata", g_bwd, 32'h5A5A_5A5A);

    do_access(4'd3, 32'h000, 32'h0, 32'h8000_1234, 1, st_n, e_at, g_we, g_wd, g_ba, g_be, g_bwd, g_bwe, g_st);
    check("lh_wdata", g_wd, 32'hFFFF_8000);
    check("lh_be", g_be, 4'b1100);
    check("lh_bwe", g_bwe, 1'b0);

    do_access(4'd4, 32'h002, 32'h0, 32'h1234_8765, 1, st_n, e_at, g_we, g_wd, g_ba, g_be, g_bwd, g_bwe, g_st);
    check("lhu_wdata", g_wd, 32'h0000_8765);

    do_access(4'd5, 32'h010, 32'h0, 32'hCAFE_F00D, 2, st_n, e_at, g_we, g_wd, g_ba, g_be, g_bwd, g_bwe, g_st);
    check("lw_wdata", g_wd, 32'hCAFE_F00D);
    check("lw_be", g_be, 4'b1111);

    do_access(4'd5, 32'h040, 32'h0, 32'h0BAD_F00D, 16, st_n, e_at, g_we, g_wd, g_ba, g_be, g_bwd, g_bwe, g_st);
    check("lastack_err", e_at, 0);
    check("lastack_wdata", g_wd, 32'h0BAD_F00D);
    check("lastack_stall", st_n, 16);

    do_access(4'd5, 32'h080, 32'h0, 32'h0, 0, st_n, e_at, g_we, g_wd, g_ba, g_be, g_bwd, g_bwe, g_st);
    check("tmo_err_cycle", e_at, 16);
    check("tmo_mem_we", g_we, 1'b0);
    check("tmo_stall", st_n, 16);
    check("tmo_stable", g_st, 1'b1);
    bus_ack = 1'b1;
    @(negedge clk);
    check("late_ack_no_err", bus_err, 1'b0);
    check("late_ack_pass_we", mem_we, 1'b1);
    @(posedge clk); #1;
    check("late_ack_no_req", bus_req, 1'b0);
    bus_ack = 1'b0;

    @(posedge clk); #1;
    ex_memop = 4'd8; ex_addr = 32'h0000_0C00; ex_sdata = 32'h1357_9BDF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rb_busy_req", bus_req, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("rb_stall0", stallreq, 1'b0);
    check("rb_mem_we0", mem_we, 1'b0);
    @(posedge clk); #1;
    check("rb_req0", bus_req, 1'b0);
    check("rb_addr0", bus_addr, 32'h0);
    check("rb_wdata0", bus_wdata, 32'h0);
    check("rb_bwe0", bus_we, 1'b0);
    rst = 1'b0; ex_memop = 4'd0; bus_ack = 1'b1;
    @(negedge clk);
    check("rb_late_ack_err", bus_err, 1'b0);
    @(posedge clk); #1;
    check("rb_late_ack_req", bus_req, 1'b0);
    bus_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory stage of the 5-stage integer pipeline. It sits between the EX/MEM pipeline register and mem_wb.
- Non-memory instructions pass straight through.
- Loads and stores run a req/ack transaction on the data bus and stall the pipeline until the transaction completes.
- Load data is aligned and extended, then presented on mem_waddr, mem_wdata and mem_we for mem_wb to capture.

Parameters:
- TIMEOUT, 16: number of BUSY cycles without bus_ack before the access is aborted. Must be at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ex_waddr  in  5  destination register
- ex_wdata  in  32  ALU result (non-memory ops)
- ex_we  in  1  register write enable
- ex_memop  in  4  memory op code (see package)
- ex_addr  in  32  effective address
- ex_sdata  in  32  store data, in the low bits
- mem_waddr  out  5  to mem_wb
- mem_wdata  out  32  to mem_wb
- mem_we  out  1  to mem_wb
- stallreq  out  1  hold EX/MEM and earlier stages
- bus_req  out  1  registered bus request
- bus_we  out  1  registered: 1 = store
- bus_addr  out  32  registered, word-aligned (low 2 bits = 0)
- bus_be  out  4  registered byte enables; be[3] = bits 31:24
- bus_wdata  out  32  registered, lane-replicated store data
- bus_rdata  in  32  read data, valid when bus_ack = 1
- bus_ack  in  1  single-cycle completion
- addr_err  out  1  one-cycle pulse: misaligned access
- bus_err  out  1  one-cycle pulse: timeout abort

Behaviour:
- Byte order is big-endian: addr[1:0] = 00 selects bits 31:24.
- Upstream holds all ex_* inputs stable while stallreq = 1.
- Reset: state IDLE, counter 0, bus_req/bus_we = 0, bus_addr/bus_be/bus_wdata = 0. Combinational outputs are forced to 0 while rst = 1. A reset during BUSY drops bus_req at that edge; any late bus_ack is ignored.
- FSM has two states, IDLE and BUSY.
- IDLE, op NONE or an undefined code: mem_waddr/mem_wdata/mem_we = ex_*; stallreq = 0. Latency 0, combinational.
- IDLE, misaligned access (half with addr[0] = 1, word with addr[1:0] != 0):
  - no bus access;
  - mem_we = 0, addr_err = 1 for that cycle, stallreq = 0.
- IDLE, aligned load or store:
  - stallreq = 1, mem_we = 0;
  - at the next edge: latch bus_addr = {addr[31:2], 2'b00}, bus_be, bus_wdata and bus_we; set bus_req = 1, counter = 0; go to BUSY.
- Byte enables: byte access → one-hot lane per addr[1:0]; half access → 1100 or 0011; word access → 1111.
- Store data replication: SB → {4{sdata[7:0]}}; SH → {2{sdata[15:0]}}; SW → sdata.
- BUSY, bus_ack = 0: stallreq = 1, counter increments.
- BUSY, bus_ack = 1 (this may happen in the first BUSY cycle, so the minimum total is 2 cycles):
  - stallreq = 0;
  - load: mem_we = ex_we, mem_waddr = ex_waddr, mem_wdata = selected lane, sign- or zero-extended per op;
  - store: mem_we = 0;
  - at the next edge: bus_req = 0, go to IDLE.
- BUSY, counter = TIMEOUT-1 with no ack: bus_err = 1, stallreq = 0, mem_we = 0; at the next edge bus_req = 0, go to IDLE. An ack arriving in that same cycle wins; no error is raised.
- bus_ack in IDLE is ignored.
- After completion, the same instruction is never reissued: stallreq = 0 lets upstream advance at that edge, and IDLE then evaluates the next instruction.
- bus_addr, bus_be, bus_wdata and bus_we are stable for the whole time bus_req = 1.

Decomposition:
- defines.v holds:
  - MemOp codes: NONE = 0, LB = 1, LBU = 2, LH = 3, LHU = 4, LW = 5, SB = 6, SH = 7, SW = 8;
  - the existing RegBus, RegAddrBus, ZeroWord and WriteDisable;
  - a MemOpBus width macro.
- One sub-module, mem_load_align: combinational. Inputs rdata, addr[1:0], op; output is the extended 32-bit value.

Test Plan:
- NONE op: ex_waddr = 3, ex_wdata = 0x1234, ex_we = 1 → same values on mem_* in the same cycle; stallreq = 0; bus_req never rises.
- LB at 0x101: bus_rdata = 0x11_80_22_33, ack in the first BUSY cycle →
  - bus_addr = 0x100, be = 0100;
  - mem_wdata = 0xFFFFFF80;
  - stallreq high exactly 1 cycle.
- LBU at the same address with the same data → mem_wdata = 0x00000080.
- SH at 0x202, sdata = 0xABCD, ack after 3 wait cycles →
  - be = 0011, bus_wdata = 0xABCDABCD, bus_we = 1;
  - mem_we = 0;
  - stallreq high for 4 cycles.
- LW at 0x003 → addr_err pulses 1 cycle, no bus_req, mem_we = 0. LH at 0x001 → same.
- LW, never acked, TIMEOUT = 16 → bus_err pulses in BUSY cycle 16, bus_req drops on the following edge, a late ack is ignored. Separately: rst asserted in BUSY cycle 2 → all outputs 0 on the next edge.
